xcorr_window: RTL and testbench
===============================

// Module: xcorr_window
// PURPOSE
//  Multi-lag sliding-window cross-correlator for two 1-bit sample streams.
//  Score per lag k = matches XNOR(x[n-k], y[n]) over the last WINDOW accepted samples.
//  Reports all lag scores plus peak lag/value and a threshold detect flag.
//  Sits after the bit slicers; feeds the sync/alignment controller. Successor to the single-lag running-balance correlator.
// PARAMETERS
//  WINDOW    16                     samples per correlation window (>=2)
//  NUM_LAGS  4                      lags evaluated, 0..NUM_LAGS-1 (>=1)
//  THRESH    12                     detect_o threshold on peak score (0..WINDOW)
//  CNT_W     $clog2(WINDOW+1)       score width (derived, not overridden)
//  LAG_W     $clog2(NUM_LAGS) min 1 lag index width (derived)
// PORTS
//  clk          in   1                   single clock, rising edge
//  reset        in   1                   asynchronous, active-low reset
//  clear_i      in   1                   sync clear: flush history, restart fill
//  valid_i      in   1                   sample strobe; sig_x_i/sig_y_i sampled when 1
//  sig_x_i      in   1                   reference stream bit
//  sig_y_i      in   1                   received stream bit
//  corr_o       out  NUM_LAGS*CNT_W      packed scores, lag k at [k*CNT_W +: CNT_W]
//  peak_lag_o   out  LAG_W               lag index of max score
//  peak_val_o   out  CNT_W               max score
//  detect_o     out  1                   peak_val_o >= THRESH, qualified by valid_o
//  valid_o      out  1                   outputs meaningful (window full)
// BEHAVIOUR
//  - Reset (reset==0, async): all history, counters and outputs to 0; state FILL.
//  - Accepted sample: valid_i==1 && clear_i==0. No valid_i -> full state holds.
//  - x delay line: NUM_LAGS-1 taps, shifts on accepted sample; tap k gives x[n-k].
//  - Per lag: WINDOW-deep match shift reg. Score += new match, -= match shifted out.
//    Score always in 0..WINDOW. No saturation needed; assertion checks bound.
//  - FSM: FILL -> RUN after FILL_N = WINDOW+NUM_LAGS-1 accepted samples (fill cnt).
//    RUN -> FILL only on clear_i or reset. valid_o=1 only in RUN (pipeline-aligned).
//  - Pipeline, latency 2 from accepting edge:
//    S1 = score update. S2 = argmax + compare; registers all outputs together.
//    Sample accepted at edge t: outputs reflect it after edge t+2.
//  - valid_o rises 2 edges after the FILL_N-th accepted sample.
//    It stays 1 through valid_i gaps; outputs hold during gaps.
//  - Argmax tie -> lowest lag index. All scores 0 -> peak_lag_o=0, peak_val_o=0.
//  - detect_o = valid_o && (peak_val_o >= THRESH). THRESH=0 -> detect_o == valid_o.
//  - clear_i: wins over simultaneous valid_i (sample dropped).
//    Next edge: history/scores/fill cnt zeroed, FSM=FILL.
//    valid_o/detect_o drop to 0 the cycle after clear_i (not pipeline-delayed).
//    corr_o/peak_* zero one edge later.
//  - Reset mid-operation: immediate async clear, same as power-up. No partial state kept.
//  - NUM_LAGS==1: peak_lag_o tied 0, argmax trivial.
// STRUCTURE
//  - xcorr_pkg: fsm enum {FILL, RUN}; function for packed-score slice index.
//  - Sub-module xcorr_lag_acc (one per lag, generate loop):
//    match shift reg + CNT_W running score. Ports clk, reset, clear, en, match, score.
//  - Top holds: x delay line, fill counter/FSM, argmax tree, S2 output registers.
// TESTING  (WINDOW=8, NUM_LAGS=4, THRESH=6, FILL_N=11)
//  1. Reset held 0, random inputs -> all outputs 0.
//     Release, no valid_i -> outputs stay 0.
//  2. y==x, random, 11 valid samples back-to-back.
//     -> valid_o=1 two edges after 11th; corr[0]=8, peak_lag_o=0, peak_val_o=8, detect_o=1.
//  3. y = x delayed 2 samples (LFSR), 20 samples.
//     -> in RUN: corr[2]=8, peak_lag_o=2, detect_o=1; other lags < 8.
//  4. x=1, y=0 constant, 11 samples -> valid_o=1, all corr 0, peak_lag_o=0, detect_o=0.
//     Then y=1 for 8 samples -> all scores 8, peak_lag_o=0 (tie rule).
//  5. In RUN, clear_i=1 with valid_i=1 -> next cycle valid_o=0; sample not counted.
//     Needs 11 new samples to re-assert valid_o.
//  6. valid_i gaps (1-in-3), pattern of test 3 -> same scores as test 3, outputs hold in gaps.
//     Async reset pulse mid-run -> outputs 0 without clock edge.

Source files
------------

// File: rtl/xcorr_pkg.sv
// xcorr_pkg: shared types and helpers for the sliding-window cross-correlator.
//   fsm_e     : fill/run state of the window controller
//   slice_lsb : LSB position of one lag's score inside a packed score vector
package xcorr_pkg;

   typedef enum logic [0:0] {
      FILL = 1'b0,
      RUN  = 1'b1
   } fsm_e;

   // Lag k occupies bits [k*width +: width] of every packed score bus.
   function automatic int slice_lsb(input int lag, input int width);
      return lag * width;
   endfunction

endpackage

// File: rtl/xcorr_lag_acc.sv
// xcorr_lag_acc: running match count for one lag over the last WINDOW samples.
//   clk    in  rising-edge clock
//   reset  in  asynchronous active-low reset
//   clear  in  synchronous flush of history and score
//   en     in  accept one match bit this cycle
//   match  in  1 when the lagged x bit equals the y bit
//   score  out number of matches currently held in the window (0..WINDOW)
module xcorr_lag_acc
   import xcorr_pkg::*;
#(
   parameter  int WINDOW = 16,
   localparam int CNT_W  = $clog2(WINDOW + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             en,
   input  logic             match,
   output logic [CNT_W-1:0] score
);

   logic [WINDOW-1:0] hist_r;

   // Match history shift register and running score; the bit leaving the
   // window is subtracted as the new one is added, so no full recount is needed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hist_r <= '0;
         score  <= '0;
      end else if (clear) begin
         hist_r <= '0;
         score  <= '0;
      end else if (en) begin
         hist_r <= {hist_r[WINDOW-2:0], match};
         score  <= score + CNT_W'(match) - CNT_W'(hist_r[WINDOW-1]);
      end else begin
         hist_r <= hist_r;
         score  <= score;
      end
   end

endmodule

// File: rtl/xcorr_window_chk.sv
// xcorr_window_chk: invariant checks on the internal lag scores.
//   clk    in  rising-edge clock
//   reset  in  asynchronous active-low reset (checks disabled while low)
//   scores in  packed lag scores, lag k at [k*CNT_W +: CNT_W]
module xcorr_window_chk
   import xcorr_pkg::*;
#(
   parameter int WINDOW   = 16,
   parameter int NUM_LAGS = 4,
   parameter int CNT_W    = 5
) (
   input logic                      clk,
   input logic                      reset,
   input logic [NUM_LAGS*CNT_W-1:0] scores
);

   logic bound_ok_s;

   // Every score must stay within 0..WINDOW.
   always_comb begin
      bound_ok_s = 1'b1;
      for (int k = 0; k < NUM_LAGS; k++) begin
         if (scores[slice_lsb(k, CNT_W) +: CNT_W] > CNT_W'(WINDOW)) begin
            bound_ok_s = 1'b0;
         end else begin
            bound_ok_s = bound_ok_s;
         end
      end
   end

   a_score_bound: assert property (@(posedge clk) disable iff (!reset) bound_ok_s);

endmodule

// File: rtl/xcorr_window.sv
// xcorr_window: multi-lag sliding-window cross-correlator for two 1-bit streams.
// Score for lag k counts XNOR(x[n-k], y[n]) over the last WINDOW accepted samples.
//   clk        in  rising-edge clock
//   reset      in  asynchronous active-low reset
//   clear_i    in  synchronous clear: flush history, restart fill (wins over valid_i)
//   valid_i    in  sample strobe
//   sig_x_i    in  reference stream bit
//   sig_y_i    in  received stream bit
//   corr_o     out packed lag scores, lag k at [k*CNT_W +: CNT_W]
//   peak_lag_o out lag of the highest score (lowest lag on ties)
//   peak_val_o out highest score
//   detect_o   out valid_o && peak_val_o >= THRESH
//   valid_o    out window full, outputs meaningful
// Pipeline: edge t captures the sample, t+1 updates scores, t+2 registers outputs.
module xcorr_window
   import xcorr_pkg::*;
#(
   parameter  int WINDOW   = 16,
   parameter  int NUM_LAGS = 4,
   parameter  int THRESH   = 12,
   localparam int CNT_W    = $clog2(WINDOW + 1),
   localparam int LAG_W    = (NUM_LAGS > 1) ? $clog2(NUM_LAGS) : 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clear_i,
   input  logic                      valid_i,
   input  logic                      sig_x_i,
   input  logic                      sig_y_i,
   output logic [NUM_LAGS*CNT_W-1:0] corr_o,
   output logic [LAG_W-1:0]          peak_lag_o,
   output logic [CNT_W-1:0]          peak_val_o,
   output logic                      detect_o,
   output logic                      valid_o
);

   // The oldest lag needs NUM_LAGS-1 extra samples before its window holds real x data.
   localparam int               FILL_N   = WINDOW + NUM_LAGS - 1;
   localparam int               FILL_W   = $clog2(FILL_N + 1);
   localparam logic [CNT_W-1:0] THRESH_V = CNT_W'(THRESH);

   logic [NUM_LAGS-1:0]       xd_r;
   logic                      y_r;
   logic                      acc_en_r;
   logic [NUM_LAGS-1:0]       match_s;
   logic [NUM_LAGS*CNT_W-1:0] score_s;
   logic [CNT_W-1:0]          cand_s;
   logic [CNT_W-1:0]          peak_val_s;
   logic [LAG_W-1:0]          peak_lag_s;
   logic                      peak_hit_s;
   fsm_e                      state_r;
   fsm_e                      state_nx_s;
   logic [FILL_W-1:0]         fill_cnt_r;
   logic                      run_d_r;

   // Capture stage: x delay line (xd_r[k] = x[n-k]) and the y bit of the accepted sample.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         xd_r     <= '0;
         y_r      <= 1'b0;
         acc_en_r <= 1'b0;
      end else if (clear_i) begin
         xd_r     <= '0;
         y_r      <= 1'b0;
         acc_en_r <= 1'b0;
      end else if (valid_i) begin
         xd_r[0] <= sig_x_i;
         for (int j = 1; j < NUM_LAGS; j++) begin
            xd_r[j] <= xd_r[j-1];
         end
         y_r      <= sig_y_i;
         acc_en_r <= 1'b1;
      end else begin
         xd_r     <= xd_r;
         y_r      <= y_r;
         acc_en_r <= 1'b0;
      end
   end

   // Score stage: one running accumulator per lag.
   for (genvar k = 0; k < NUM_LAGS; k++) begin : g_lag
      assign match_s[k] = ~(xd_r[k] ^ y_r);

      xcorr_lag_acc #(
         .WINDOW (WINDOW)
      ) u_acc (
         .clk   (clk),
         .reset (reset),
         .clear (clear_i),
         .en    (acc_en_r),
         .match (match_s[k]),
         .score (score_s[slice_lsb(k, CNT_W) +: CNT_W])
      );
   end

   xcorr_window_chk #(
      .WINDOW   (WINDOW),
      .NUM_LAGS (NUM_LAGS),
      .CNT_W    (CNT_W)
   ) u_chk (
      .clk    (clk),
      .reset  (reset),
      .scores (score_s)
   );

   // Argmax scan: strict greater-than keeps the lowest lag on ties; all-zero gives lag 0.
   always_comb begin
      peak_val_s = score_s[CNT_W-1:0];
      peak_lag_s = '0;
      cand_s     = '0;
      for (int k = 1; k < NUM_LAGS; k++) begin
         cand_s = score_s[slice_lsb(k, CNT_W) +: CNT_W];
         if (cand_s > peak_val_s) begin
            peak_val_s = cand_s;
            peak_lag_s = LAG_W'(k);
         end else begin
            peak_val_s = peak_val_s;
            peak_lag_s = peak_lag_s;
         end
      end
      peak_hit_s = (peak_val_s >= THRESH_V);
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= FILL;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // FSM next state: RUN once FILL_N samples have been accepted since the last clear.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         FILL: begin
            if (clear_i) begin
               state_nx_s = FILL;
            end else if (valid_i && (fill_cnt_r == FILL_W'(FILL_N - 1))) begin
               state_nx_s = RUN;
            end else begin
               state_nx_s = FILL;
            end
         end
         RUN: begin
            if (clear_i) begin
               state_nx_s = FILL;
            end else begin
               state_nx_s = RUN;
            end
         end
         default: state_nx_s = FILL;
      endcase
   end

   // Fill counter: counts accepted samples while filling, freezes in RUN.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fill_cnt_r <= '0;
      end else if (clear_i) begin
         fill_cnt_r <= '0;
      end else if ((state_r == FILL) && valid_i) begin
         fill_cnt_r <= fill_cnt_r + FILL_W'(1);
      end else begin
         fill_cnt_r <= fill_cnt_r;
      end
   end

   // Delays RUN by one edge so valid_o lines up with the score of the filling sample.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         run_d_r <= 1'b0;
      end else if (clear_i) begin
         run_d_r <= 1'b0;
      end else begin
         run_d_r <= (state_r == RUN);
      end
   end

   // Output stage: scores and peak follow the pipeline; valid/detect drop at once on clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         corr_o     <= '0;
         peak_lag_o <= '0;
         peak_val_o <= '0;
         valid_o    <= 1'b0;
         detect_o   <= 1'b0;
      end else begin
         corr_o     <= score_s;
         peak_lag_o <= peak_lag_s;
         peak_val_o <= peak_val_s;
         valid_o    <= run_d_r & ~clear_i;
         detect_o   <= run_d_r & ~clear_i & peak_hit_s;
      end
   end

endmodule

// File: tb/tb_xcorr_window.sv
// tb_xcorr_window: directed sequence with random sample data, checked against a
// history-queue reference model of the correlator.
module tb_xcorr_window;

   localparam int WINDOW   = 8;
   localparam int NUM_LAGS = 4;
   localparam int THRESH   = 6;
   localparam int CNT_W    = 4;
   localparam int LAG_W    = 2;
   localparam int FILL_N   = WINDOW + NUM_LAGS - 1;

   logic clk = 1'b0;
   logic reset;
   logic clear_i;
   logic valid_i;
   logic sig_x_i;
   logic sig_y_i;
   logic [NUM_LAGS*CNT_W-1:0] corr_o;
   logic [LAG_W-1:0]          peak_lag_o;
   logic [CNT_W-1:0]          peak_val_o;
   logic                      detect_o;
   logic                      valid_o;

   int n_assert = 0;
   int n_fail   = 0;
   int edge_n   = 0;

   // Accepted samples since last clear/reset, with the edge that accepted each.
   bit xs[$];
   bit ys[$];
   int es[$];

   int   t3_score[NUM_LAGS];
   logic [6:0] lfsr;

   always #5 clk = ~clk;

   xcorr_window #(
      .WINDOW   (WINDOW),
      .NUM_LAGS (NUM_LAGS),
      .THRESH   (THRESH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .clear_i    (clear_i),
      .valid_i    (valid_i),
      .sig_x_i    (sig_x_i),
      .sig_y_i    (sig_y_i),
      .corr_o     (corr_o),
      .peak_lag_o (peak_lag_o),
      .peak_val_o (peak_val_o),
      .detect_o   (detect_o),
      .valid_o    (valid_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [CNT_W-1:0] corr_k(input int k);
      return corr_o[k*CNT_W +: CNT_W];
   endfunction

   // Matches of lag k over the WINDOW newest samples of the first m accepted ones.
   function automatic int lag_score(input int m, input int k);
      int s = 0;
      for (int n = m - WINDOW; n < m; n++) begin
         if (xs[n-k] == ys[n]) s++;
      end
      return s;
   endfunction

   task automatic model_clear();
      xs.delete();
      ys.delete();
      es.delete();
   endtask

   // Outputs after edge e reflect samples accepted at edges <= e-2.
   task automatic check_model();
      int m    = 0;
      int best = -1;
      int bl   = 0;
      int s;
      for (int i = 0; i < es.size(); i++) begin
         if (es[i] <= edge_n - 2) m++;
      end
      chk("valid_o", valid_o, 32'(m >= FILL_N));
      if (m >= FILL_N) begin
         for (int k = 0; k < NUM_LAGS; k++) begin
            s = lag_score(m, k);
            chk($sformatf("corr[%0d]@%0d", k, edge_n), corr_k(k), s);
            if (s > best) begin
               best = s;
               bl   = k;
            end
         end
         chk("peak_lag_o", peak_lag_o, bl);
         chk("peak_val_o", peak_val_o, best);
         chk("detect_o", detect_o, 32'(best >= THRESH));
      end else begin
         chk("detect_o_fill", detect_o, 0);
      end
   endtask

   task automatic cycle(input logic v, input logic x, input logic y, input logic c);
      valid_i = v;
      sig_x_i = x;
      sig_y_i = y;
      clear_i = c;
      @(posedge clk);
      edge_n++;
      if (c) begin
         model_clear();
      end else if (v) begin
         xs.push_back(x);
         ys.push_back(y);
         es.push_back(edge_n);
      end
      #1;
      check_model();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " corr_o"}, corr_o, 0);
      chk({tag, " peak_lag_o"}, peak_lag_o, 0);
      chk({tag, " peak_val_o"}, peak_val_o, 0);
      chk({tag, " detect_o"}, detect_o, 0);
      chk({tag, " valid_o"}, valid_o, 0);
   endtask

   function automatic logic lfsr_step(inout logic [6:0] st);
      st = {st[5:0], st[6] ^ st[5]};
      return st[0];
   endfunction

   // Drives 20 samples of x (LFSR) with y = x delayed by 2, valid every 'gap' cycles.
   task automatic run_delay2(input int gap);
      bit xq[$];
      logic xb;
      logic yb;
      lfsr = 7'h5A;
      for (int n = 0; n < 20; n++) begin
         xb = lfsr_step(lfsr);
         xq.push_back(xb);
         yb = (n >= 2) ? xq[n-2] : 1'b0;
         for (int g = 1; g < gap; g++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
         cycle(1'b1, xb, yb, 1'b0);
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      logic rx;

      // 1. Reset held with random inputs, then released with no valid_i.
      reset   = 1'b0;
      clear_i = 1'b0;
      valid_i = 1'b0;
      sig_x_i = 1'b0;
      sig_y_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         valid_i = 1'($urandom);
         clear_i = 1'($urandom);
         sig_x_i = 1'($urandom);
         sig_y_i = 1'($urandom);
         @(posedge clk);
         edge_n++;
         #1;
         chk_zero("t1 in_reset");
      end
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'($urandom), 1'($urandom), 1'b0);
         chk_zero("t1 idle");
      end

      // 2. y == x, 11 back-to-back samples.
      for (int i = 0; i < FILL_N; i++) begin
         rx = 1'($urandom);
         cycle(1'b1, rx, rx, 1'b0);
      end
      chk("t2 valid_o_edge1", valid_o, 0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      chk("t2 valid_o_edge2", valid_o, 0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      chk("t2 valid_o", valid_o, 1);
      chk("t2 corr0", corr_k(0), 8);
      chk("t2 peak_lag_o", peak_lag_o, 0);
      chk("t2 peak_val_o", peak_val_o, 8);
      chk("t2 detect_o", detect_o, 1);

      // 3. y = x delayed 2 samples.
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      run_delay2(1);
      chk("t3 valid_o", valid_o, 1);
      chk("t3 corr2", corr_k(2), 8);
      chk("t3 peak_lag_o", peak_lag_o, 2);
      chk("t3 detect_o", detect_o, 1);
      for (int k = 0; k < NUM_LAGS; k++) begin
         t3_score[k] = lag_score(xs.size(), k);
         if (k != 2) chk($sformatf("t3 corr%0d_below8", k), 32'(corr_k(k) < 4'd8), 1);
      end

      // 4. x=1, y=0 constant, then y=1: all-zero and all-tie cases.
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < FILL_N; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      chk("t4 valid_o", valid_o, 1);
      chk("t4 corr_all0", corr_o, 0);
      chk("t4 peak_lag_o", peak_lag_o, 0);
      chk("t4 detect_o", detect_o, 0);
      for (int i = 0; i < WINDOW; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < NUM_LAGS; k++) chk($sformatf("t4 corr%0d_tie", k), corr_k(k), 8);
      chk("t4 peak_lag_tie", peak_lag_o, 0);
      chk("t4 detect_tie", detect_o, 1);

      // 5. Clear with simultaneous valid in RUN.
      cycle(1'b1, 1'b1, 1'b1, 1'b1);
      chk("t5 valid_o_drop", valid_o, 0);
      chk("t5 detect_o_drop", detect_o, 0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      chk("t5 corr_zero", corr_o, 0);
      chk("t5 peak_val_zero", peak_val_o, 0);
      for (int i = 0; i < FILL_N - 1; i++) cycle(1'b1, 1'($urandom), 1'($urandom), 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      chk("t5 valid_o_10", valid_o, 0);
      cycle(1'b1, 1'($urandom), 1'($urandom), 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      chk("t5 valid_o_11", valid_o, 1);

      // 6. Pattern of test 3 with valid 1-in-3, then async reset mid-run.
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      run_delay2(3);
      for (int k = 0; k < NUM_LAGS; k++) chk($sformatf("t6 corr%0d_vs_t3", k), corr_k(k), t3_score[k]);
      chk("t6 peak_lag_o", peak_lag_o, 2);
      chk("t6 detect_o", detect_o, 1);
      #2;
      reset = 1'b0;
      #1;
      chk_zero("t6 async_reset");
      model_clear();
      reset = 1'b1;
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      chk_zero("t6 after_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
